// File: rtl/reptile_pkg.sv
// Shared types for the Reptile memory arbiter: bus widths, port id and command record.
// Optional lock feature elsewhere is selected with `define REPTILE_ARB_LOCK_EN.
package reptile_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic              valid;
    port_id_t          port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/reptile_mem_arbiter_if.sv
// Requester-side bus of the Reptile memory arbiter; master = core/DMA, slave = arbiter.
// The lock wire exists only when REPTILE_ARB_LOCK_EN is defined.
interface reptile_mem_arbiter_if;
  import reptile_pkg::*;

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
`ifdef REPTILE_ARB_LOCK_EN
  logic              lock;

  modport master (output valid, we, addr, wdata, lock, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, lock, output ready, rvalid, rdata);
`else
  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
`endif

endinterface

// File: rtl/reptile_rr_pick.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to
// the port that did not win last.
module reptile_rr_pick
  import reptile_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last_grant,
  output logic       grant_valid,
  output port_id_t   grant_port
);

  always_comb begin
    grant_valid = |valid;
    grant_port  = 1'b0;
    if (&valid)
      grant_port = other_port(last_grant);
    else if (valid[1])
      grant_port = 1'b1;
  end

endmodule

// File: rtl/reptile_mem_arbiter.sv
// Two-port round-robin arbiter for the Reptile memory port: ARB -> CMD -> RSP pipeline.
// Define REPTILE_ARB_LOCK_EN to add per-port lock inputs that hold the grant.
module reptile_mem_arbiter
  import reptile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  reptile_mem_arbiter_if.slave req0,
  reptile_mem_arbiter_if.slave req1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_data_out,
  output logic                 mem_memwt,
  input  logic [DATA_W-1:0]    mem_data_in
);

  logic [1:0]        req_valid;
  logic [1:0]        pick_valid;
  logic              win_valid;
  port_id_t          win_port;
  port_id_t          last_grant;
  logic              hs;
  logic [1:0]        ready;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  cmd_t              cmd;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  assign req_valid = {req1.valid, req0.valid};

`ifdef REPTILE_ARB_LOCK_EN
  logic     lock_active;
  port_id_t lock_owner;
  logic     win_lock;

  // While a lock is held the non-owner is hidden from the picker entirely.
  always_comb begin
    pick_valid = req_valid;
    if (lock_active) begin
      if (lock_owner == 1'b0)
        pick_valid[1] = 1'b0;
      else
        pick_valid[0] = 1'b0;
    end
  end

  assign win_lock = win_port ? req1.lock : req0.lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (hs) begin
      lock_active <= win_lock;
      lock_owner  <= win_port;
    end else if (lock_active && !req_valid[lock_owner]) begin
      lock_active <= 1'b0;
    end
  end
`else
  assign pick_valid = req_valid;
`endif

  reptile_rr_pick u_pick (
    .valid       (pick_valid),
    .last_grant  (last_grant),
    .grant_valid (win_valid),
    .grant_port  (win_port)
  );

  assign hs = win_valid && !rst;

  always_comb begin
    ready = 2'b00;
    if (hs)
      ready[win_port] = 1'b1;
  end

  assign req0.ready = ready[0];
  assign req1.ready = ready[1];

  assign win_we    = win_port ? req1.we    : req0.we;
  assign win_addr  = win_port ? req1.addr  : req0.addr;
  assign win_wdata = win_port ? req1.wdata : req0.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= '0;
      last_grant <= 1'b1;
    end else if (hs) begin
      cmd.valid  <= 1'b1;
      cmd.port   <= win_port;
      cmd.we     <= win_we;
      cmd.addr   <= win_addr;
      cmd.wdata  <= win_wdata;
      last_grant <= win_port;
    end else begin
      cmd        <= '0;
    end
  end

  // Read data is sampled at the end of the CMD cycle, since the memory read is asynchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= 2'b00;
      if (cmd.valid && !cmd.we) begin
        if (cmd.port == 1'b0) begin
          rvalid_q[0] <= 1'b1;
          rdata0_q    <= mem_data_in;
        end else begin
          rvalid_q[1] <= 1'b1;
          rdata1_q    <= mem_data_in;
        end
      end
    end
  end

  assign req0.rvalid = rvalid_q[0];
  assign req1.rvalid = rvalid_q[1];
  assign req0.rdata  = rdata0_q;
  assign req1.rdata  = rdata1_q;

  // Gating with rst keeps an in-flight command from writing during the reset cycle.
  assign mem_memwt    = cmd.valid && cmd.we && !rst;
  assign mem_address  = (cmd.valid && !rst) ? cmd.addr : '0;
  assign mem_data_out = rst ? '0 : cmd.wdata;

endmodule
